// File: rtl/pspi_master_ctrl.sv
// ---------------------------------------------------------------------------
// pspi_master_ctrl
//
// Transaction controller for the PSPI master. Accepts one byte from the host,
// builds the outgoing frame (parity frame or raw byte), shifts it out
// MSB-first on mosi under a mode-0 sclk with cs_n asserted, and simultaneously
// shifts in miso. At the end of the frame it reports the received payload and
// the received parity check.
//
// Parity frame: frame[7:1] = data[6:0], frame[0] = XOR of data[6:0].
// Raw frame   : frame = data.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous reset, active-low
//   start    in   transaction request, accepted only while idle
//   par_en   in   1 = parity frame, 0 = raw byte (captured at accept)
//   tx_data  in   byte to send (captured at accept)
//   busy     out  high from the accept edge until back in IDLE
//   done     out  one-cycle pulse when rx_data / par_err are updated
//   rx_data  out  received payload, held until the next done
//   par_err  out  received parity mismatch, held until the next done
//   sclk     out  serial clock, idle low
//   cs_n     out  chip select, active low
//   mosi     out  serial data out
//   miso     in   serial data in
//
// Parameter
//   CLK_DIV  sclk half-period in clk cycles (1..255)
// ---------------------------------------------------------------------------
module pspi_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       par_en,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       par_err,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] tx_lat;
    logic       par_lat;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;

    logic       phase_end;
    logic       last_fall;

    // Outgoing frame for the latched byte and mode.
    function automatic logic [7:0] build_frame(input logic p, input logic [7:0] d);
        return p ? {d[6:0], ^d[6:0]} : d;
    endfunction

    // Payload extracted from the received frame.
    function automatic logic [7:0] rx_payload(input logic p, input logic [7:0] f);
        return p ? {1'b0, f[7:1]} : f;
    endfunction

    // Parity mismatch: the received parity bit disagrees with the XOR of the
    // received data bits, i.e. the XOR over the whole frame is 1.
    function automatic logic rx_parity_err(input logic p, input logic [7:0] f);
        return p ? (f[0] ^ (^f[7:1])) : 1'b0;
    endfunction

    // mosi is taken straight from the MSB of the shift register, so it stays
    // a registered output without a separate flop; the register is cleared on
    // FINISH and reset, which parks mosi low.
    assign mosi      = tx_shift[7];

    assign phase_end = (div_cnt == DIV_LAST);
    assign last_fall = phase_end && sclk && (bit_cnt == 3'd7);

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (last_fall) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- datapath and registered outputs ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= 8'h00;
            par_err  <= 1'b0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            tx_lat   <= 8'h00;
            par_lat  <= 1'b0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            div_cnt  <= 8'h00;
            bit_cnt  <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_lat  <= tx_data;
                        par_lat <= par_en;
                        busy    <= 1'b1;
                    end
                end

                LOAD: begin
                    tx_shift <= build_frame(par_lat, tx_lat);
                    cs_n     <= 1'b0;
                    sclk     <= 1'b0;
                    div_cnt  <= 8'h00;
                    bit_cnt  <= 3'd0;
                end

                SHIFT: begin
                    if (phase_end) begin
                        div_cnt <= 8'h00;
                        if (!sclk) begin
                            // rising edge: capture the slave's bit
                            sclk     <= 1'b1;
                            rx_shift <= {rx_shift[6:0], miso};
                        end else begin
                            // falling edge: present the next bit, except after
                            // the 8th bit where the frame ends
                            sclk <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 3'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                FINISH: begin
                    cs_n     <= 1'b1;
                    tx_shift <= 8'h00;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    rx_data  <= rx_payload(par_lat, rx_shift);
                    par_err  <= rx_parity_err(par_lat, rx_shift);
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pspi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pspi_master_ctrl
//
// Self-checking bench for pspi_master_ctrl. One instance runs with
// CLK_DIV=4 (main scenarios), a second with CLK_DIV=1 (fastest sclk).
// A slave model either loops mosi back to miso or shifts out a chosen byte,
// and expected results come from the frame rules written as arithmetic.
// ---------------------------------------------------------------------------
module tb_pspi_master_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---- instance with CLK_DIV = 4 ----
    logic       start   = 1'b0;
    logic       par_en  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       busy, done, par_err, sclk, cs_n, mosi, miso;
    logic [7:0] rx_data;

    logic       loop_en    = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    logic [2:0] slave_idx  = 3'd7;
    logic [7:0] mosi_cap   = 8'h00;
    int         rise_cnt   = 0;

    assign miso = loop_en ? mosi : slave_byte[slave_idx];

    always @(negedge cs_n) slave_idx = 3'd7;
    always @(negedge sclk) slave_idx = slave_idx - 3'd1;
    always @(posedge sclk) begin
        mosi_cap = {mosi_cap[6:0], mosi};
        rise_cnt++;
    end

    pspi_master_ctrl #(.CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .par_en(par_en),
        .tx_data(tx_data), .busy(busy), .done(done), .rx_data(rx_data),
        .par_err(par_err), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    // ---- instance with CLK_DIV = 1, loopback ----
    logic       start1   = 1'b0;
    logic       par_en1  = 1'b0;
    logic [7:0] tx_data1 = 8'h00;
    logic       busy1, done1, par_err1, sclk1, cs_n1, mosi1;
    logic [7:0] rx_data1;

    pspi_master_ctrl #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .par_en(par_en1),
        .tx_data(tx_data1), .busy(busy1), .done(done1), .rx_data(rx_data1),
        .par_err(par_err1), .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(mosi1)
    );

    // ---- reference model ----
    function automatic int ones(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [7:0] ref_frame(input logic p, input logic [7:0] d);
        logic [7:0] low7 = d & 8'h7F;
        if (!p) return d;
        return 8'((low7 << 1) | 8'(ones(low7) % 2));
    endfunction

    function automatic logic [7:0] ref_rx(input logic p, input logic [7:0] f);
        return p ? (f >> 1) : f;
    endfunction

    function automatic logic ref_err(input logic p, input logic [7:0] f);
        return p ? logic'(ones(f) % 2) : 1'b0;
    endfunction

    // ---- one full transaction on the CLK_DIV=4 instance ----
    task automatic run_txn(input logic p, input logic [7:0] d, input logic lp,
                           input logic [7:0] s, input string nm);
        int         cyc;
        int         cs_bad;
        logic [7:0] exp_mosi;
        logic [7:0] exp_rx;
        logic       exp_err;
        logic [7:0] rx_hold;
        exp_mosi = ref_frame(p, d);
        exp_rx   = ref_rx(p, lp ? exp_mosi : s);
        exp_err  = ref_err(p, lp ? exp_mosi : s);
        loop_en    = lp;
        slave_byte = s;
        @(negedge clk);
        mosi_cap = 8'h00;
        rise_cnt = 0;
        start    = 1'b1;
        par_en   = p;
        tx_data  = d;
        @(posedge clk); #1;
        start   = 1'b0;
        // disturb the inputs while the frame is in flight
        tx_data = 8'($urandom);
        par_en  = 1'($urandom);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_at_accept: got %b want 1", nm, busy);
        end
        cyc    = 0;
        cs_bad = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (done !== 1'b1 && cs_n !== 1'b0 && cyc >= 1) cs_bad++;
        end
        n_tests++;
        if (cyc !== 66) begin
            n_fail++;
            $display("FAIL %s done_latency: got %0d want 66", nm, cyc);
        end
        n_tests++;
        if (mosi_cap !== exp_mosi || rise_cnt !== 8) begin
            n_fail++;
            $display("FAIL %s mosi_frame: got %h (%0d rises) want %h (8 rises)",
                     nm, mosi_cap, rise_cnt, exp_mosi);
        end
        n_tests++;
        if (rx_data !== exp_rx || par_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s rx_result: got %h/%b want %h/%b",
                     nm, rx_data, par_err, exp_rx, exp_err);
        end
        n_tests++;
        if (cs_bad !== 0 || busy !== 1'b0 || cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin
            n_fail++;
            $display("FAIL %s frame_ctrl: cs_bad=%0d busy=%b cs_n=%b sclk=%b mosi=%b want 0/0/1/0/0",
                     nm, cs_bad, busy, cs_n, sclk, mosi);
        end
        rx_hold = rx_data;
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0 || rx_data !== rx_hold) begin
            n_fail++;
            $display("FAIL %s done_pulse: done=%b rx=%h want 0/%h", nm, done, rx_data, rx_hold);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, cs_n, sclk, mosi, par_err, rx_data} !== {5'b00100, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: got b%b d%b cs%b sc%b mo%b pe%b rx%h want 0 0 1 0 0 0 00",
                     busy, done, cs_n, sclk, mosi, par_err, rx_data);
        end
        n_tests++;
        if ({busy1, done1, cs_n1, sclk1, mosi1, par_err1, rx_data1} !== {5'b00100, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state_div1: got b%b d%b cs%b sc%b mo%b",
                     busy1, done1, cs_n1, sclk1, mosi1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loopback;
        run_txn(1'b1, 8'h35, 1'b1, 8'h00, "loop_35");
        run_txn(1'b1, 8'h07, 1'b1, 8'h00, "loop_07");
    endtask

    task automatic test_parity_err;
        run_txn(1'b1, 8'h35, 1'b0, 8'h6B, "perr_6B");
    endtask

    task automatic test_raw;
        run_txn(1'b0, 8'hA5, 1'b0, 8'h3C, "raw_A5_3C");
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            run_txn(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), "random");
        end
    endtask

    task automatic test_held_start;
        int cyc;
        loop_en = 1'b1;
        @(negedge clk);
        mosi_cap = 8'h00;
        rise_cnt = 0;
        start    = 1'b1;
        par_en   = 1'b1;
        tx_data  = 8'h35;
        @(posedge clk); #1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 20) begin
                start   = 1'b0;
                tx_data = 8'hFF;
            end
            if (cyc == 21) start = 1'b1;
        end
        n_tests++;
        if (cyc !== 66 || mosi_cap !== 8'h6A || rx_data !== 8'h35 || par_err !== 1'b0) begin
            n_fail++;
            $display("FAIL held_first: lat=%0d mosi=%h rx=%h pe=%b want 66 6A 35 0",
                     cyc, mosi_cap, rx_data, par_err);
        end
        mosi_cap = 8'h00;
        rise_cnt = 0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_busy_at_done: got %b want 0", busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL held_reaccept: busy got %b want 1", busy);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++;
        if (cyc !== 66 || mosi_cap !== 8'hFF || rx_data !== 8'h7F || par_err !== 1'b0) begin
            n_fail++;
            $display("FAIL held_second: lat=%0d mosi=%h rx=%h pe=%b want 66 FF 7F 0",
                     cyc, mosi_cap, rx_data, par_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clkdiv1;
        int         cyc;
        int         last_rise;
        int         per_bad;
        int         nr;
        logic       prev;
        logic       p;
        logic [7:0] d;
        for (int i = 0; i < 3; i++) begin
            p = 1'($urandom);
            d = 8'($urandom);
            @(negedge clk);
            start1   = 1'b1;
            par_en1  = p;
            tx_data1 = d;
            @(posedge clk); #1;
            start1 = 1'b0;
            cyc = 0; last_rise = -1; per_bad = 0; nr = 0;
            prev = sclk1;
            while (done1 !== 1'b1 && cyc < 500) begin
                @(posedge clk); #1;
                cyc++;
                if (sclk1 === 1'b1 && prev === 1'b0) begin
                    if (last_rise >= 0 && cyc - last_rise != 2) per_bad++;
                    last_rise = cyc;
                    nr++;
                end
                prev = sclk1;
            end
            n_tests++;
            if (cyc !== 18 || per_bad !== 0 || nr !== 8) begin
                n_fail++;
                $display("FAIL div1_timing: lat=%0d bad_periods=%0d rises=%0d want 18 0 8",
                         cyc, per_bad, nr);
            end
            n_tests++;
            if (rx_data1 !== ref_rx(p, ref_frame(p, d)) || par_err1 !== 1'b0) begin
                n_fail++;
                $display("FAIL div1_rx: got %h/%b want %h/0",
                         rx_data1, par_err1, ref_rx(p, ref_frame(p, d)));
            end
        end
    endtask

    task automatic test_mid_reset;
        int cyc;
        int done_seen;
        loop_en = 1'b1;
        @(negedge clk);
        rise_cnt = 0;
        start    = 1'b1;
        par_en   = 1'b1;
        tx_data  = 8'h35;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (rise_cnt < 5 && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (rise_cnt !== 5 || cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || mosi !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: rises=%0d cs_n=%b sclk=%b busy=%b done=%b mosi=%b want 5 1 0 0 0 0",
                     rise_cnt, cs_n, sclk, busy, done, mosi);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done === 1'b1 || cs_n !== 1'b1) done_seen++;
        end
        n_tests++;
        if (done_seen !== 0) begin
            n_fail++;
            $display("FAIL midreset_aborted: activity cycles got %0d want 0", done_seen);
        end
        run_txn(1'b1, 8'hC3, 1'b1, 8'h00, "after_reset");
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_parity_err();
        test_raw();
        test_held_start();
        test_clkdiv1();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pspi_master_ctrl.md
Name: pspi_master_ctrl

Overview:
Transaction controller for the PSPI master. It accepts one byte from the host, builds the parity frame and serialises it MSB-first on MOSI under a generated SCLK with chip-select. It deserialises MISO in the same frame, checks received parity and reports the result. Frame format: in parity mode, frame[7:1] = data[6:0] and frame[0] = XOR of data[6:0]; in raw mode, frame = data.

Parameters:
CLK_DIV, 4, SCLK half-period in clk cycles; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  request a transaction; accepted only when busy=0
par_en  input  1  1 = parity frame mode, 0 = raw 8-bit; captured at accept
tx_data  input  8  byte to send; captured at accept
busy  output  1  high from the accept edge until return to IDLE
done  output  1  one-cycle pulse when rx_data and par_err are valid
rx_data  output  8  received payload; held until next done
par_err  output  1  received parity mismatch; held until next done
sclk  output  1  serial clock, mode 0 (idle low)
cs_n  output  1  chip select, active low
mosi  output  1  serial data out
miso  input  1  serial data in

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, rx_data=0, par_err=0, sclk=0, cs_n=1, mosi=0. Divider, bit counter and shift registers are cleared. This applies from any state, including mid-frame. The frame is aborted with cs_n high and no done.
- States: IDLE, LOAD, SHIFT, FINISH.
- IDLE: when start=1, the controller latches tx_data and par_en, sets busy=1 and moves to LOAD. start is ignored in every other state.
- LOAD (1 cycle):
  - tx_shift = generated frame; cs_n=0; mosi=frame[7].
  - Divider and bit counter are cleared; go to SHIFT.
- SHIFT: 8 bits. Each bit is 2*CLK_DIV cycles: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - On the edge that drives sclk 0->1, the controller samples miso into rx_shift LSB (shift left).
  - On the edge that drives sclk 1->0, it shifts tx_shift left and puts the next bit on mosi.
  - After the 8th high phase ends: sclk=0, go to FINISH.
  - SHIFT lasts exactly 16*CLK_DIV cycles.
- FINISH (1 cycle):
  - cs_n=1, mosi=0, done=1, busy=0 at the following edge.
  - Parity mode: rx_data = {1'b0, rx_shift[7:1]}, par_err = rx_shift[0] XOR (XOR of rx_shift[7:1]).
  - Raw mode: rx_data = rx_shift, par_err=0.
  - Go to IDLE.
- Timing: if start is accepted at edge k, done is high during the cycle after edge k+16*CLK_DIV+2. The earliest next accept is one cycle after done.
- sclk, cs_n and mosi are registered outputs with no combinational paths from inputs.
- A change to tx_data or par_en while busy has no effect on the frame in flight.

Test Plan:
- CLK_DIV=4, par_en=1, tx_data=0x35, miso looped to mosi -> mosi bits 0x6A MSB-first; 8 sclk rising edges; rx_data=0x35, par_err=0; done high 66 cycles after accept.
- par_en=1, tx_data=0x07, loopback -> frame 0x0F on mosi; rx_data=0x07, par_err=0.
- par_en=1, slave model drives miso=0x6B -> rx_data=0x35, par_err=1, done single-cycle.
- par_en=0, tx_data=0xA5, slave drives 0x3C -> mosi 0xA5; rx_data=0x3C, par_err=0.
- start held high continuously, plus a second pulse with tx_data=0xFF mid-frame -> first frame unaltered; new frame starts only after done; CLK_DIV=1 gives sclk period of 2 clk cycles.
- rst_n=0 for one cycle at bit 4 of a frame -> next cycle cs_n=1, sclk=0, busy=0, no done; a following start produces a complete, correct frame.
